// File: rtl/instr_fetch_queue.sv
// Instruction fetch unit: program-loadable single-port RAM feeding a small decode queue.
// Optional stall-cycle counter is enabled by defining FETCH_PERF_CNT_EN.
module instr_fetch_queue #(
    parameter int          INSTR_W    = 16,
    parameter int          ADDR_W     = 9,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         prog_we_i,
    input  logic [ADDR_W-1:0]            prog_addr_i,
    input  logic [INSTR_W-1:0]           prog_data_i,
    input  logic                         redirect_i,
    input  logic [31:0]                  redirect_pc_i,
    input  logic                         instr_ready_i,
    output logic                         instr_valid_o,
    output logic [INSTR_W-1:0]           instr_o,
    output logic [31:0]                  pc_o,
    output logic [$clog2(FIFO_DEPTH):0]  count_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]                  stall_cycles_o
`endif
);

    localparam int                PTR_W = $clog2(FIFO_DEPTH);
    localparam int                CNT_W = PTR_W + 1;
    localparam int                DEPTH = 1 << ADDR_W;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(FIFO_DEPTH);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] rd_data;

    logic [31:0]        fetch_pc_q;
    logic               inflight_q;
    logic [31:0]        inflight_pc_q;

    logic [INSTR_W-1:0] q_instr [FIFO_DEPTH];
    logic [31:0]        q_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [CNT_W-1:0]   count_q;

    logic issue;
    logic push;
    logic pop;

    // Counting the in-flight read against capacity guarantees its push always has room.
    assign issue = !prog_we_i && !redirect_i &&
                   ((count_q + CNT_W'(inflight_q)) < FULL);
    assign push  = inflight_q && !redirect_i;
    assign pop   = instr_valid_o && instr_ready_i;

    assign instr_valid_o = (count_q != '0);
    assign instr_o       = q_instr[rd_ptr_q];
    assign pc_o          = q_pc[rd_ptr_q];
    assign count_o       = count_q;

    // Single port: a program write takes the port, so no read is issued that cycle.
    always_ff @(posedge clk_i) begin
        if (prog_we_i) begin
            mem[prog_addr_i] <= prog_data_i;
        end else if (issue) begin
            rd_data <= mem[fetch_pc_q[ADDR_W:1]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr[wr_ptr_q] <= rd_data;
            q_pc[wr_ptr_q]    <= inflight_pc_q;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else if (redirect_i) begin
            fetch_pc_q <= redirect_pc_i;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= fetch_pc_q;
                fetch_pc_q    <= fetch_pc_q + 32'd2;
            end
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            stall_cycles_o <= '0;
        end else if (!instr_valid_o && (stall_cycles_o != 32'hFFFF_FFFF)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus random traffic,
// compared every cycle against a queue-level reference model.
module tb_instr_fetch_queue;

    localparam int          INSTR_W    = 16;
    localparam int          ADDR_W     = 9;
    localparam int          FIFO_DEPTH = 4;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;

    logic                         clk_i;
    logic                         reset_i;
    logic                         prog_we_i;
    logic [ADDR_W-1:0]            prog_addr_i;
    logic [INSTR_W-1:0]           prog_data_i;
    logic                         redirect_i;
    logic [31:0]                  redirect_pc_i;
    logic                         instr_ready_i;
    logic                         instr_valid_o;
    logic [INSTR_W-1:0]           instr_o;
    logic [31:0]                  pc_o;
    logic [$clog2(FIFO_DEPTH):0]  count_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]                  stall_cycles_o;
`endif

    int compares   = 0;
    int mismatches = 0;

    instr_fetch_queue #(
        .INSTR_W    (INSTR_W),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .prog_we_i      (prog_we_i),
        .prog_addr_i    (prog_addr_i),
        .prog_data_i    (prog_data_i),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .instr_ready_i  (instr_ready_i),
        .instr_valid_o  (instr_valid_o),
        .instr_o        (instr_o),
        .pc_o           (pc_o),
        .count_o        (count_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cycles_o (stall_cycles_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [31:0]        pc;
    } entry_t;

    // Reference model: visible queue, one pending RAM read, fetch address, memory image.
    entry_t             m_q[$];
    entry_t             m_pend;
    bit                 m_pend_valid;
    logic [31:0]        m_fpc;
    logic [31:0]        m_stall;
    logic [INSTR_W-1:0] m_mem [1 << ADDR_W];

    task automatic modelReset();
        m_q.delete();
        m_pend_valid = 1'b0;
        m_fpc        = RESET_PC;
        m_stall      = '0;
    endtask

    task automatic modelEdge();
        bit issue;
        if (!reset_i) begin
            if (m_q.size() == 0 && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
            issue = !prog_we_i && !redirect_i &&
                    ((m_q.size() + int'(m_pend_valid)) < FIFO_DEPTH);
            if (redirect_i) begin
                m_q.delete();
                m_pend_valid = 1'b0;
                m_fpc        = redirect_pc_i;
            end else begin
                if (m_q.size() != 0 && instr_ready_i) void'(m_q.pop_front());
                if (m_pend_valid) m_q.push_back(m_pend);
                m_pend_valid = issue;
                if (issue) begin
                    m_pend.instr = m_mem[m_fpc[ADDR_W:1]];
                    m_pend.pc    = m_fpc;
                    m_fpc        = m_fpc + 32'd2;
                end
            end
        end
        if (prog_we_i) m_mem[prog_addr_i] = prog_data_i;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            mismatches++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkValue("valid", 32'(instr_valid_o), 32'(m_q.size() != 0));
        checkValue("count", 32'(count_o), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            checkValue("instr", 32'(instr_o), 32'(m_q[0].instr));
            checkValue("pc", pc_o, m_q[0].pc);
        end
`ifdef FETCH_PERF_CNT_EN
        checkValue("stall_cycles", stall_cycles_o, m_stall);
`endif
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] addr,
                                 input logic [INSTR_W-1:0] data, input logic redir,
                                 input logic [31:0] rpc, input logic rdy);
        prog_we_i     = we;
        prog_addr_i   = addr;
        prog_data_i   = data;
        redirect_i    = redir;
        redirect_pc_i = rpc;
        instr_ready_i = rdy;
        @(posedge clk_i);
        modelEdge();
        #1;
        checkOutput();
    endtask

    task automatic stepIdle(input logic rdy);
        applyStimulus(1'b0, '0, '0, 1'b0, 32'h0, rdy);
    endtask

    task automatic redirectTo(input logic [31:0] pc, input logic rdy);
        applyStimulus(1'b0, '0, '0, 1'b1, pc, rdy);
    endtask

    initial begin
        reset_i       = 1'b1;
        prog_we_i     = 1'b0;
        prog_addr_i   = '0;
        prog_data_i   = '0;
        redirect_i    = 1'b0;
        redirect_pc_i = '0;
        instr_ready_i = 1'b0;
        modelReset();
        #1;
        checkOutput();

        // Program load under reset: mem[i] = A000 + i across the whole array.
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            applyStimulus(1'b1, ADDR_W'(i), INSTR_W'(16'hA000 + i), 1'b0, 32'h0, 1'b0);
        end
        checkValue("reset_count", 32'(count_o), 32'h0);

        // Streaming after reset release
        reset_i = 1'b0;
        stepIdle(1'b1);
        checkValue("first_edge_valid", 32'(instr_valid_o), 32'h0);
        stepIdle(1'b1);
        checkValue("stream_head_instr", 32'(instr_o), 32'hA000);
        checkValue("stream_head_pc", pc_o, 32'h0);
        for (int k = 1; k < 12; k++) begin
            stepIdle(1'b1);
            checkValue("stream_no_bubble", 32'(instr_valid_o), 32'h1);
            checkValue("stream_instr", 32'(instr_o), 32'(16'hA000 + k));
            checkValue("stream_pc", pc_o, 32'(2 * k));
        end

        // Backpressure from pc 0: queue fills to depth, then drains in order
        redirectTo(32'h0, 1'b0);
        for (int k = 0; k < 8; k++) stepIdle(1'b0);
        checkValue("bp_count_full", 32'(count_o), 32'h4);
        checkValue("bp_head", 32'(instr_o), 32'hA000);
        for (int k = 0; k < 8; k++) stepIdle(1'b1);

        // Redirect with a full queue
        for (int k = 0; k < 6; k++) stepIdle(1'b0);
        checkValue("pre_redirect_full", 32'(count_o), 32'h4);
        redirectTo(32'h10, 1'b0);
        checkValue("redirect_flush", 32'(count_o), 32'h0);
        stepIdle(1'b0);
        stepIdle(1'b0);
        checkValue("redirect_instr", 32'(instr_o), 32'hA008);
        checkValue("redirect_pc", pc_o, 32'h10);
        for (int k = 0; k < 4; k++) stepIdle(1'b1);

        // In-flight read discarded by a redirect
        redirectTo(32'h20, 1'b1);
        stepIdle(1'b1);
        redirectTo(32'h40, 1'b1);
        checkValue("inflight_discard", 32'(count_o), 32'h0);
        stepIdle(1'b1);
        stepIdle(1'b1);
        checkValue("after_discard_pc", pc_o, 32'h40);
        checkValue("after_discard_instr", 32'(instr_o), 32'hA020);

        // Memory index wrap
        redirectTo(32'h3FE, 1'b1);
        stepIdle(1'b1);
        stepIdle(1'b1);
        checkValue("wrap_last_instr", 32'(instr_o), 32'hA1FF);
        checkValue("wrap_last_pc", pc_o, 32'h3FE);
        stepIdle(1'b1);
        checkValue("wrap_first_instr", 32'(instr_o), 32'hA000);
        checkValue("wrap_first_pc", pc_o, 32'h400);

        // Program write mid-stream: one bubble, then the new word appears at pc 0x414
        for (int k = 0; k < 3; k++) stepIdle(1'b1);
        applyStimulus(1'b1, ADDR_W'(10), 16'hBEEF, 1'b0, 32'h0, 1'b1);
        stepIdle(1'b1);
        checkValue("prog_bubble", 32'(instr_valid_o), 32'h0);
        for (int k = 0; k < 12; k++) stepIdle(1'b1);

        // Asynchronous reset mid-operation keeps RAM contents
        for (int k = 0; k < 3; k++) stepIdle(1'b0);
        reset_i = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkValue("async_reset_count", 32'(count_o), 32'h0);
        stepIdle(1'b0);
        reset_i = 1'b0;
        stepIdle(1'b1);
        stepIdle(1'b1);
        checkValue("post_reset_instr", 32'(instr_o), 32'hA000);
        checkValue("post_reset_pc", pc_o, RESET_PC);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom() % 8) == 0,
                          ADDR_W'($urandom()),
                          INSTR_W'($urandom()),
                          ($urandom() % 16) == 0,
                          $urandom(),
                          ($urandom() % 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
